// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential OPW x OPW unsigned multiplier built around one
// shared 4x4 array multiplier. Each cycle in MUL feeds one nibble pair to
// the array and shift-accumulates the 8-bit partial product into acc.
// Optional build macro MULT_SEQ_ZERO_SKIP_EN: a zero operand at accept skips
// MUL and goes straight to DONE with a zero result.

// 4x4 unsigned array multiplier: AND-gate partial products summed row by row.
module tt_um_array_mult_structural_GnahsLliw (
    input  logic [3:0] m,
    input  logic [3:0] q,
    output logic [7:0] p
);
    logic [3:0] pp0, pp1, pp2, pp3;
    logic [4:0] row1;
    logic [4:0] row2;
    logic [4:0] row3;

    // Partial-product rows and their ripple additions.
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        pp0  = m & {4{q[0]}};
        pp1  = m & {4{q[1]}};
        pp2  = m & {4{q[2]}};
        pp3  = m & {4{q[3]}};
        row1 = {2'b00, pp0[3:1]} + {1'b0, pp1};
        row2 = {1'b0, row1[4:1]} + {1'b0, pp2};
        row3 = {1'b0, row2[4:1]} + {1'b0, pp3};
        p    = {row3, row2[0], row1[0], pp0[0]};
    end
endmodule

module mult_seq_ctrl #(
    parameter int OPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*OPW-1:0] out_p,
    output logic             busy
);
    localparam int N  = OPW / 4;
    localparam int AW = 2 * OPW;
    // Nibble indices are 2 bits wide: OPW tops out at 16, i.e. N = 4.
    localparam logic [1:0] LAST = 2'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [1:0]      i_q;
    logic [1:0]      j_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [3:0]      mul_m;
    logic [3:0]      mul_q;
    logic [7:0]      mul_p;
    logic [2:0]      pos;
    logic [AW-1:0]   term;

    tt_um_array_mult_structural_GnahsLliw u_mul (
        .m (mul_m),
        .q (mul_q),
        .p (mul_p)
    );

    // Select the current nibble pair (zero outside MUL) and form the next accumulator value.
    always_comb begin
        mul_m = '0;
        mul_q = '0;
        if (state_q == S_MUL) begin
            for (int k = 0; k < N; k++) begin
                if (i_q == 2'(k)) mul_m = a_q[4*k +: 4];
                if (j_q == 2'(k)) mul_q = b_q[4*k +: 4];
            end
        end
        pos   = {1'b0, i_q} + {1'b0, j_q};
        term  = AW'(mul_p) << {pos, 2'b00};
        acc_d = acc_q + term;
    end

    // Control FSM with registered out_valid/busy; reset wins over every transition.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        acc_q  <= '0;
                        i_q    <= '0;
                        j_q    <= '0;
                        busy_q <= 1'b1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                        if (in_a == '0 || in_b == '0) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_MUL;
                        end
`else
                        state_q <= S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            i_q         <= '0;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            i_q <= i_q + 2'd1;
                        end
                    end else begin
                        j_q <= j_q + 2'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_p     = acc_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: directed tests on an OPW=8 instance, then
// randomized back-to-back traffic with output stalls on OPW=4/8/12/16
// instances. Expected products go into per-instance queues at accept time
// and are compared when the product is handed over.
module tb_mult_seq_ctrl;
    localparam int NRAND = 1000;
`ifdef MULT_SEQ_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 4;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;
    logic        rand_go;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    mult_seq_ctrl #(.OPW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair, wait (bounded) for in_ready, record the expected product.
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check("accept_ready", 64'(in_ready), 64'(1));
        sb.push_back(64'(a) * 64'(b));
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and pop/compare the product.
    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (sb.size() != 0) check({tag, "_p"}, 64'(out_p), sb.pop_front());
        else                check({tag, "_sb_empty"}, 64'(1), 64'(0));
    endtask

    // Randomized traffic on each legal operand width.
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int OW = 4 * (g + 1);
        logic            iv;
        logic            ir;
        logic [OW-1:0]   a;
        logic [OW-1:0]   b;
        logic            ov;
        logic            ordy;
        logic [2*OW-1:0] p;
        logic            bz;
        logic [63:0]     q[$];
        int              popped;
        logic            done;

        mult_seq_ctrl #(.OPW(OW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (a),
            .in_b      (b),
            .out_valid (ov),
            .out_ready (ordy),
            .out_p     (p),
            .busy      (bz)
        );

        initial begin : drv
            iv = 1'b0;
            a  = '0;
            b  = '0;
            wait (rand_go);
            tick();
            for (int n = 0; n < NRAND; n++) begin
                a  = OW'($urandom);
                b  = OW'($urandom);
                if ($urandom_range(0, 15) == 0) a = '0;
                if ($urandom_range(0, 15) == 0) b = '0;
                iv = 1'b1;
                for (int w = 0; w < 200 && !ir; w++) tick();
                if (!ir) begin
                    check($sformatf("rand%0d_in_timeout", OW), 64'(0), 64'(1));
                    break;
                end
                q.push_back(64'(a) * 64'(b));
                tick();
            end
            iv = 1'b0;
        end

        initial begin : mon
            ordy   = 1'b0;
            done   = 1'b0;
            popped = 0;
            wait (rand_go);
            for (int c = 0; c < 60000 && popped < NRAND; c++) begin
                tick();
                ordy = ($urandom_range(0, 2) != 0);
                if (ov && ordy) begin
                    if (q.size() != 0) check($sformatf("rand%0d_p", OW), 64'(p), q.pop_front());
                    else               check($sformatf("rand%0d_sb_empty", OW), 64'(1), 64'(0));
                    popped++;
                end
            end
            if (popped < NRAND) check($sformatf("rand%0d_timeout", OW), 64'(popped), 64'(NRAND));
            ordy = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        logic [7:0] probe_exp [4];
        probe_exp = '{8'h24, 8'h23, 8'h14, 8'h13};
        rst       = 1'b1;
        rand_go   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_in_ready",  64'(in_ready),  64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_out_p",     64'(out_p),     64'(0));
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'(1));

        // Maximum operands, consumer always ready.
        out_ready = 1'b1;
        accept(8'hFF, 8'hFF);
        wait_out("ff", 4);
        check("ff_busy_done", 64'(busy), 64'(1));
        tick();
        check("ff_in_ready_after", 64'(in_ready),  64'(1));
        check("ff_out_valid_after", 64'(out_valid), 64'(0));

        // Iteration order through the multiplier probe, then backpressure.
        out_ready = 1'b0;
        accept(8'h12, 8'h34);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("probe%0d", k), 64'({dut.mul_m, dut.mul_q}), 64'(probe_exp[k]));
            check($sformatf("mul_busy%0d", k), 64'({busy, in_ready, out_valid}), 64'(3'b100));
            tick();
        end
        wait_out("a12b34", 0);
        for (int s = 0; s < 3; s++) begin
            if (s == 0) begin
                in_valid = 1'b1;
                in_a     = 8'h03;
                in_b     = 8'h03;
            end
            tick();
            in_valid = 1'b0;
            check($sformatf("stall%0d_valid", s), 64'(out_valid), 64'(1));
            check($sformatf("stall%0d_p", s),     64'(out_p),     64'(16'h03A8));
            check($sformatf("stall%0d_ready", s), 64'(in_ready),  64'(0));
        end
        // Offer operands in the consume cycle: they must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h03;
        in_b      = 8'h03;
        tick();
        in_valid  = 1'b0;
        check("consume_busy",      64'(busy),      64'(0));
        check("consume_out_valid", 64'(out_valid), 64'(0));
        check("consume_in_ready",  64'(in_ready),  64'(1));
        check("idle_keeps_p",      64'(out_p),     64'(16'h03A8));

        // Reset in the middle of MUL discards the operation.
        accept(8'h55, 8'h66);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy",      64'(busy),      64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        accept(8'h0A, 8'h0B);
        wait_out("a0ab0b", 4);

        // Zero operand.
        accept(8'h00, 8'h5A);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        check("zero_probe", 64'({dut.mul_m, dut.mul_q}), 64'(0));
`endif
        wait_out("zero", ZERO_LAT);
        tick();
        check("zero_consumed", 64'(out_valid), 64'(0));

        // Randomized traffic on all widths.
        out_ready = 1'b0;
        rand_go   = 1'b1;
        begin
            int c;
            c = 0;
            while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done)
                   && c < 70000) begin
                tick();
                c++;
            end
            check("rand_all_done",
                  64'({g_rand[0].done, g_rand[1].done, g_rand[2].done, g_rand[3].done}),
                  64'(4'hF));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
